// File: rtl/parallel_sum_pkg.sv
// Shared types and helpers for parallel_sum_collector and its per-lane accumulators.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package parallel_sum_pkg;

  // Output-side FSM: EMPTY = nothing presented, FULL = a frame total is presented
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } collector_state_t;

  // Result of a saturating add: clamped sum plus a flag saying the clamp engaged
  typedef struct packed {
    logic signed [31:0] sum;
    logic               ovf;
  } sat_res_t;

  // Beat-counter width for a frame of 'frame' beats (frame >= 2)
  function automatic int cnt_w(input int frame);
    return (frame < 2) ? 1 : $clog2(frame);
  endfunction

  // Signed add of acc + x clamped to the aw-bit two's complement range
  function automatic sat_res_t sat_add(input logic signed [31:0] acc,
                                       input logic signed [31:0] x,
                                       input int                 aw);
    longint   s;
    longint   hi;
    longint   lo;
    sat_res_t r;
    s  = longint'(acc) + longint'(x);
    hi = (longint'(1) <<< (aw - 1)) - 1;
    lo = -(longint'(1) <<< (aw - 1));
    r.ovf = 1'b0;
    if (s > hi) begin
      s     = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      s     = lo;
      r.ovf = 1'b1;
    end
    r.sum = 32'(s);
    return r;
  endfunction

endpackage

// File: rtl/sum_lane_acc.sv
// One lane of the frame accumulator: running sum, optional saturation, sticky overflow.
// Latency: acc_next/ovf_next are combinational from acc and x; acc updates on accept.
// Backpressure: none locally; the parent only asserts accept for beats it actually takes.
// Build option: PARALLEL_SUM_COLLECTOR_SAT_EN selects saturating arithmetic + sticky ovf.
module sum_lane_acc
  import parallel_sum_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = W + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 last,
  input  logic signed [W-1:0]  x,
  output logic signed [AW-1:0] acc_next,
  output logic                 ovf_next
);

  logic signed [AW-1:0] acc;

`ifdef PARALLEL_SUM_COLLECTOR_SAT_EN
  sat_res_t sat;
  logic     sticky;

  // Clamped next value; ovf_next folds in every earlier clamp of this frame
  always_comb begin
    sat      = sat_add(32'(acc), 32'(x), AW);
    acc_next = sat.sum[AW-1:0];
    ovf_next = sticky | sat.ovf;
  end

  // Sticky overflow: set by any clamp in the frame, cleared when the frame closes
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 1'b0;
    end else if (accept) begin
      sticky <= last ? 1'b0 : ovf_next;
    end
  end
`else
  // Plain two's complement add, wraps modulo 2^AW; overflow is never reported
  always_comb begin
    acc_next = acc + AW'(x);
    ovf_next = 1'b0;
  end
`endif

  // Accumulator restarts from zero on the beat that closes the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= last ? '0 : acc_next;
    end
  end

endmodule

// File: rtl/parallel_sum_collector.sv
// Per-lane frame totals over FRAME beats, double-buffered: frame k presented while k+1 builds.
// Latency: out_valid rises one cycle after the FRAME-th beat is accepted.
// Backpressure: only the last beat of a frame stalls, and only while the previous total is unread.
// Build option: PARALLEL_SUM_COLLECTOR_SAT_EN enables saturating lanes and per-lane ovf.
module parallel_sum_collector
  import parallel_sum_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int FRAME = 16,
  parameter int AW    = W + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [W-1:0]          sum      [N],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [AW-1:0]         total    [N],
  output logic [N-1:0]                 ovf,
  output logic [$clog2(FRAME)-1:0]     beat_cnt
);

  localparam int               CNT_W = cnt_w(FRAME);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME - 1);

  collector_state_t     state;
  logic                 accept;
  logic                 last_beat;
  logic                 frame_end;
  logic signed [AW-1:0] lane_next [N];
  logic [N-1:0]         lane_ovf;

  assign last_beat = (beat_cnt == LAST);
  assign in_ready  = !(out_valid && !out_ready && last_beat);
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && last_beat;

  for (genvar g = 0; g < N; g++) begin : g_lane
    sum_lane_acc #(
      .W  (W),
      .AW (AW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .accept   (accept),
      .last     (last_beat),
      .x        (sum[g]),
      .acc_next (lane_next[g]),
      .ovf_next (lane_ovf[g])
    );
  end

  // Beat position within the frame; holds across in_valid gaps
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // Output FSM and holding registers; a frame end during a handshake reloads with no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      ovf       <= '0;
      for (int i = 0; i < N; i++) total[i] <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (frame_end) begin
            state     <= FULL;
            out_valid <= 1'b1;
            ovf       <= lane_ovf;
            for (int i = 0; i < N; i++) total[i] <= lane_next[i];
          end
        end
        FULL: begin
          if (frame_end) begin
            // Only reachable with out_ready=1: the last beat is stalled otherwise
            ovf <= lane_ovf;
            for (int i = 0; i < N; i++) total[i] <= lane_next[i];
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
